// File: rtl/mc14500_pkg.sv
// mc14500_pkg: shared I/O bus constants and types for the MC14500B ICU family
package mc14500_pkg;
  localparam int IO_ADDR_W = 3;
  localparam int IO_BITS = 8;
  localparam int PULSE_CYCLES_DEF = 16;
  typedef logic [IO_ADDR_W-1:0] io_addr_t;
endpackage

// File: rtl/mc14599_out_latch_pulse_tmr.sv
// mc14599_pulse_tmr: per-bit monostable down-counter; expire strobes the cycle before it reaches zero
module mc14599_pulse_tmr #(
  parameter int PULSE_CYCLES = 16,
  parameter int TMR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic cancel,
  output logic expire
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || cancel) cnt <= '0;
    else if (load) cnt <= TMR_W'(PULSE_CYCLES);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expire = (cnt == TMR_W'(1)) && !load && !cancel;
endmodule

// File: rtl/mc14599_out_latch.sv
// mc14599_out_latch: 8-bit addressable output latch with readback; timed outputs when MC14599_PULSE_EN is defined
module mc14599_out_latch
  import mc14500_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int TMR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               wd,
  input  io_addr_t           a,
  input  logic               d,
  input  logic               pls,
  output logic [IO_BITS-1:0] q,
  output logic               rd,
  output logic               rd_oe
);
  logic               we;
  logic [IO_BITS-1:0] sel;
  logic [IO_BITS-1:0] expire;
  assign we = ce && wd;
  assign sel = IO_BITS'(1) << a;
`ifdef MC14599_PULSE_EN
  for (genvar i = 0; i < IO_BITS; i++) begin : g_tmr
    mc14599_pulse_tmr #(.PULSE_CYCLES(PULSE_CYCLES), .TMR_W(TMR_W)) u_tmr (
      .clk(clk),
      .rst(rst),
      .load(we && sel[i] && d && pls),
      .cancel(we && sel[i] && !(d && pls)),
      .expire(expire[i])
    );
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{pls, TMR_W'(PULSE_CYCLES)};
  assign expire = '0;
`endif
  // a write to a bit overrides its own timer expiring in the same cycle
  always_ff @(posedge clk)
    if (rst) begin
      q <= '0;
      rd <= 1'b0;
      rd_oe <= 1'b0;
    end else begin
      q <= we ? ((q & ~sel & ~expire) | (d ? sel : '0)) : (q & ~expire);
      rd_oe <= ce && !wd;
      if (ce && !wd) rd <= q[a];
    end
endmodule

// File: tb/tb_mc14599_out_latch.sv
// tb_mc14599_out_latch: directed self-checking bench; timed-output steps run when MC14599_PULSE_EN is defined
module tb_mc14599_out_latch;
  logic clk = 1'b0;
  logic rst = 1'b1, ce = 1'b0, wd = 1'b0, d = 1'b0, pls = 1'b0;
  logic [2:0] a = '0;
  logic [7:0] q;
  logic rd, rd_oe;
  int tests = 0, fails = 0;
  mc14599_out_latch #(.PULSE_CYCLES(4), .TMR_W(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .wd(wd), .a(a), .d(d), .pls(pls),
    .q(q), .rd(rd), .rd_oe(rd_oe)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] aa, input logic dd, input logic pp);
    ce = 1'b1; wd = 1'b1; a = aa; d = dd; pls = pp;
    tick();
  endtask
  task automatic rdc(input logic [2:0] aa);
    ce = 1'b1; wd = 1'b0; a = aa; d = 1'b0; pls = 1'b0;
    tick();
  endtask
  task automatic idle();
    ce = 1'b0; wd = 1'b0; pls = 1'b0;
    tick();
  endtask
  initial begin
    ce = 1'b1; wd = 1'b1; d = 1'b1; a = 3'd1; pls = 1'b1;
    tick();
    chk("rst_q0", q, 8'h00); chk("rst_oe0", {7'b0, rd_oe}, 8'h00);
    tick();
    chk("rst_q1", q, 8'h00); chk("rst_oe1", {7'b0, rd_oe}, 8'h00);
    rst = 1'b0;
    idle();
    chk("post_rst_q", q, 8'h00); chk("post_rst_oe", {7'b0, rd_oe}, 8'h00);
    wr(3'd3, 1'b1, 1'b0); chk("wr3", q, 8'h08); chk("wr_oe", {7'b0, rd_oe}, 8'h00);
    wr(3'd5, 1'b1, 1'b0); chk("wr5", q, 8'h28);
    wr(3'd3, 1'b0, 1'b0); chk("clr3", q, 8'h20);
    rdc(3'd5); chk("rd5", {7'b0, rd}, 8'h01); chk("rd5_oe", {7'b0, rd_oe}, 8'h01);
    rdc(3'd4); chk("rd4", {7'b0, rd}, 8'h00); chk("rd4_oe", {7'b0, rd_oe}, 8'h01);
    idle(); chk("idle_oe", {7'b0, rd_oe}, 8'h00); chk("idle_q", q, 8'h20);
    wr(3'd2, 1'b1, 1'b0); chk("wr2", q, 8'h24);
    rdc(3'd2); chk("b2b_rd", {7'b0, rd}, 8'h01);
    idle(); chk("rd_hold", {7'b0, rd}, 8'h01);
    wr(3'd2, 1'b0, 1'b0); wr(3'd5, 1'b0, 1'b0); chk("clr_all", q, 8'h00);
`ifdef MC14599_PULSE_EN
    wr(3'd0, 1'b1, 1'b1); chk("pls_c0", q, 8'h01);
    for (int i = 1; i < 4; i++) begin idle(); chk("pls_hi", q, 8'h01); end
    idle(); chk("pls_expired", q, 8'h00);
    idle(); chk("pls_stays0", q, 8'h00);
    wr(3'd0, 1'b1, 1'b1); idle(); wr(3'd0, 1'b1, 1'b1); chk("retrig", q, 8'h01);
    for (int i = 1; i < 4; i++) begin idle(); chk("retrig_hi", q, 8'h01); end
    idle(); chk("retrig_end", q, 8'h00);
    wr(3'd0, 1'b1, 1'b1); idle(); wr(3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin idle(); chk("latch_over", q, 8'h01); end
    wr(3'd0, 1'b0, 1'b0); chk("latch_clr", q, 8'h00);
    wr(3'd0, 1'b1, 1'b1); idle();
    rst = 1'b1; idle(); chk("pls_rst", q, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin idle(); chk("pls_rst_quiet", q, 8'h00); end
    wr(3'd0, 1'b1, 1'b1); idle(); rdc(3'd0); chk("rd_pls", {7'b0, rd}, 8'h01); idle();
    wr(3'd0, 1'b1, 1'b0); chk("exp_wr_wins", q, 8'h01);
    for (int i = 0; i < 6; i++) begin idle(); chk("exp_wr_hold", q, 8'h01); end
`else
    wr(3'd7, 1'b1, 1'b1); chk("nopls_wr7", q, 8'h80);
    for (int i = 0; i < 300; i++) idle();
    chk("nopls_hold", q, 8'h80);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
